feature_sample_assembler: RTL and testbench

- Sits between the accelerator's DMA read channel and the tree-inference engine in the rtl_trees accelerator.
- Accepts 64-bit DMA beats. Each beat carries two IEEE-754 single-precision features: low word first, high word second.
- Assembles one complete sample vector and presents it to the inference engine over a valid/ready handshake.
- Counts samples, and signals done after the configured sample count has been consumed.

---
 rtl/feature_sample_assembler.sv | 209 ++++++++++++++++++++
 tb/tb_feature_sample_assembler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/feature_sample_assembler.sv
// Packs 64-bit DMA beats (two FP32 features each) into one sample vector for the tree-inference engine.
// Build option FEATURE_ASM_PINGPONG_EN: fill one buffer while the other is presented downstream.
module feature_sample_assembler #(
   parameter int MAX_FEATURES = 32,
   parameter int FEAT_W       = 32,
   parameter int DMA_W        = 64,
   parameter int CNT_W        = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [$clog2(MAX_FEATURES):0]   n_features,
   input  logic [CNT_W-1:0]                n_samples,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [DMA_W-1:0]                in_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [MAX_FEATURES*FEAT_W-1:0]  out_features,
   output logic                            out_last,
   output logic                            busy,
   output logic                            done,
   output logic                            cfg_err
);

   localparam int NF_W  = $clog2(MAX_FEATURES) + 1;
   localparam int BC_W  = $clog2(MAX_FEATURES);
   localparam int VEC_W = MAX_FEATURES * FEAT_W;

   // Handshakes: a beat moves when in_valid && in_ready, a vector moves when
   // out_valid && out_ready, both on the rising clock edge. Neither ready nor
   // valid depends combinationally on the partner signal.
   typedef enum logic [1:0] {IDLE, FILL, HOLD, FINISH} state_t;

   state_t            state, state_nxt;
   logic [NF_W-1:0]   nf_q;
   logic [CNT_W-1:0]  ns_q;
   logic [BC_W-1:0]   beat_cnt;
   logic [CNT_W-1:0]  sample_cnt;
   logic [BC_W-1:0]   half_m1;
   logic              cfg_legal;
   logic              last_beat;
   logic              last_sample;
   logic              in_fire;
   logic              out_fire;

   assign cfg_legal   = (n_features != '0) && !n_features[0] &&
                        (n_features <= NF_W'(MAX_FEATURES));
   assign half_m1     = nf_q[NF_W-1:1] - BC_W'(1);
   assign last_beat   = (beat_cnt == half_m1);
   assign last_sample = (sample_cnt == ns_q - CNT_W'(1));

`ifdef FEATURE_ASM_PINGPONG_EN

   logic [VEC_W-1:0]  buf_q [2];
   logic [1:0]        full;
   logic              wr_sel;
   logic              rd_sel;
   logic [CNT_W-1:0]  fill_cnt;

   assign out_features = buf_q[rd_sel];

   // FILL: samples still arriving; HOLD: everything filled, draining the last vectors.
   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      done      = (state == FINISH);
      in_ready  = (state == FILL) && !full[wr_sel];
      out_valid = ((state == FILL) || (state == HOLD)) && full[rd_sel];
      out_last  = out_valid && last_sample;
      in_fire   = in_valid && in_ready;
      out_fire  = out_valid && out_ready;
      case (state)
         IDLE:    if (start && cfg_legal) state_nxt = (n_samples == '0) ? FINISH : FILL;
         FILL:    if (in_fire && last_beat && (fill_cnt == ns_q - CNT_W'(1))) state_nxt = HOLD;
         HOLD:    if (out_fire && last_sample) state_nxt = FINISH;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cfg_err    <= 1'b0;
         nf_q       <= '0;
         ns_q       <= '0;
         beat_cnt   <= '0;
         sample_cnt <= '0;
         fill_cnt   <= '0;
         full       <= '0;
         wr_sel     <= 1'b0;
         rd_sel     <= 1'b0;
         buf_q[0]   <= '0;
         buf_q[1]   <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) begin
            if (!cfg_legal) begin
               cfg_err <= 1'b1;
            end else begin
               cfg_err    <= 1'b0;
               nf_q       <= n_features;
               ns_q       <= n_samples;
               beat_cnt   <= '0;
               sample_cnt <= '0;
               fill_cnt   <= '0;
               full       <= '0;
               wr_sel     <= 1'b0;
               rd_sel     <= 1'b0;
               buf_q[0]   <= '0;
               buf_q[1]   <= '0;
            end
         end
         // A write and a read never target the same buffer: one needs it empty, the other full.
         if (in_fire) begin
            for (int b = 0; b < MAX_FEATURES/2; b++)
               if (beat_cnt == BC_W'(b)) buf_q[wr_sel][b*DMA_W +: DMA_W] <= in_data;
            if (last_beat) begin
               beat_cnt     <= '0;
               full[wr_sel] <= 1'b1;
               wr_sel       <= ~wr_sel;
               fill_cnt     <= fill_cnt + CNT_W'(1);
            end else begin
               beat_cnt <= beat_cnt + BC_W'(1);
            end
         end
         if (out_fire) begin
            full[rd_sel]  <= 1'b0;
            buf_q[rd_sel] <= '0;
            rd_sel        <= ~rd_sel;
            sample_cnt    <= sample_cnt + CNT_W'(1);
         end
      end
   end

`else

   logic [VEC_W-1:0]  buf_q;

   assign out_features = buf_q;

   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      done      = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      case (state)
         IDLE:    if (start && cfg_legal) state_nxt = (n_samples == '0) ? FINISH : FILL;
         FILL: begin
            in_ready = 1'b1;
            if (in_valid && last_beat) state_nxt = HOLD;
         end
         HOLD: begin
            out_valid = 1'b1;
            out_last  = last_sample;
            if (out_ready) state_nxt = last_sample ? FINISH : FILL;
         end
         FINISH: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cfg_err    <= 1'b0;
         nf_q       <= '0;
         ns_q       <= '0;
         beat_cnt   <= '0;
         sample_cnt <= '0;
         buf_q      <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) begin
            if (!cfg_legal) begin
               cfg_err <= 1'b1;
            end else begin
               cfg_err    <= 1'b0;
               nf_q       <= n_features;
               ns_q       <= n_samples;
               beat_cnt   <= '0;
               sample_cnt <= '0;
               buf_q      <= '0;
            end
         end
         if (in_fire) begin
            for (int b = 0; b < MAX_FEATURES/2; b++)
               if (beat_cnt == BC_W'(b)) buf_q[b*DMA_W +: DMA_W] <= in_data;
            beat_cnt <= last_beat ? '0 : beat_cnt + BC_W'(1);
         end
         // Clearing on hand-off keeps unused high slots zero for the next sample.
         if (out_fire) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
            if (!last_sample) buf_q <= '0;
         end
      end
   end

`endif

endmodule

// File: tb/tb_feature_sample_assembler.sv
// Randomized bench for feature_sample_assembler: expected vectors are built from the generated
// feature values (feature i at bits i*32), then checked against every presented vector.
module tb_feature_sample_assembler;

   localparam int VEC_W = 1024;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [5:0]        n_features;
   logic [31:0]       n_samples;
   logic              in_valid;
   logic              in_ready;
   logic [63:0]       in_data;
   logic              out_valid;
   logic              out_ready;
   logic [VEC_W-1:0]  out_features;
   logic              out_last;
   logic              busy;
   logic              done;
   logic              cfg_err;

   int n_tests = 0;
   int n_fail  = 0;

   logic [VEC_W-1:0] exp_q[$];
   bit               last_q[$];

   feature_sample_assembler dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .n_features   (n_features),
      .n_samples    (n_samples),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_features (out_features),
      .out_last     (out_last),
      .busy         (busy),
      .done         (done),
      .cfg_err      (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [VEC_W-1:0] got, input logic [VEC_W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         int w;
         w = 0;
         n_fail++;
         for (int i = 31; i >= 0; i--)
            if (got[i*32 +: 32] !== exp[i*32 +: 32]) w = i;
         $display("FAIL %s: word %0d got %0h expected %0h", tag, w, got[w*32 +: 32], exp[w*32 +: 32]);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_in_ready"},  in_ready, 0);
      check({tag, "_out_last"},  out_last, 0);
      check({tag, "_busy"},      busy, 0);
      check({tag, "_done"},      done, 0);
      check({tag, "_cfg_err"},   cfg_err, 0);
      check({tag, "_features"},  out_features, '0);
   endtask

   // One complete run; cycles = negedges from the first post-start cycle to the done cycle.
   task automatic run(input int nf, input int ns, input int vpct, input int rpct,
                      input bit stall, input bit pattern, output int cycles);
      logic [63:0]      beats[$];
      logic [VEC_W-1:0] v;
      logic [31:0]      lo, hi;
      int  bi = 0;
      int  stall_left;
      bit  prev_last_beat = 0;
      bit  prev_hs = 0;
      bit  prev_final_hs;
      bit  finished = 0;
      bit  was_last;
      exp_q.delete();
      last_q.delete();
      for (int s = 0; s < ns; s++) begin
         v = '0;
         for (int i = 0; i < nf; i += 2) begin
            lo = pattern ? 32'(i)     : $urandom;
            hi = pattern ? 32'(i + 1) : $urandom;
            v[i*32 +: 32]     = lo;
            v[(i+1)*32 +: 32] = hi;
            beats.push_back({hi, lo});
         end
         exp_q.push_back(v);
         last_q.push_back(s == ns - 1);
      end
      stall_left    = stall ? 10 : 0;
      prev_final_hs = (ns == 0);
      cycles        = 0;
      @(negedge clk);
      start      = 1'b1;
      n_features = 6'(nf);
      n_samples  = 32'(ns);
      @(negedge clk);
      start = 1'b0;
      check("cfg_err_clear", cfg_err, 0);
      while (!finished && cycles < 4000) begin
         if (prev_last_beat) check("valid_latency", out_valid, 1);
         if (prev_hs && bi < beats.size()) check("ready_latency", in_ready, 1);
         if (prev_final_hs) begin
            check("done_pulse", done, 1);
            check("busy_in_finish", busy, 1);
            finished = 1;
         end else begin
            check("done_early", done, 0);
         end
         if (exp_q.size() == 0) check("no_valid", out_valid, 0);
         prev_last_beat = 0;
         prev_hs        = 0;
         prev_final_hs  = 0;
         if (finished) begin
            start     = 1'b0;
            in_valid  = 1'b0;
            out_ready = 1'b0;
         end else begin
            // Stray starts while busy must be ignored (an odd count would raise cfg_err).
            start      = ($urandom_range(9) == 0);
            n_features = 6'd7;
            in_valid   = (bi < beats.size()) && ($urandom_range(99) < vpct);
            in_data    = in_valid ? beats[bi] : {$urandom, $urandom};
            if (out_valid && stall_left > 0) begin
               out_ready = 1'b0;
               stall_left--;
            end else begin
               out_ready = ($urandom_range(99) < rpct);
            end
            if (out_valid && exp_q.size() > 0) begin
               check("features", out_features, exp_q[0]);
               check("out_last", out_last, last_q[0]);
`ifndef FEATURE_ASM_PINGPONG_EN
               check("in_ready_in_hold", in_ready, 0);
`endif
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  was_last      = last_q.pop_front();
                  prev_hs       = 1;
                  prev_final_hs = was_last;
                  stall_left    = stall ? 10 : 0;
               end
            end
            if (in_valid && in_ready) begin
               bi++;
               if (bi % (nf / 2) == 0) prev_last_beat = 1;
            end
         end
         @(negedge clk);
         if (!finished) cycles++;
      end
      start     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("run_finished", finished, 1);
      check("all_consumed", exp_q.size(), 0);
      check("done_one_cycle", done, 0);
      check("busy_falls", busy, 0);
      check("no_stray_cfg_err", cfg_err, 0);
   endtask

   initial begin
      int cyc;
      int nf_bad[3] = '{7, 0, 34};
      rst        = 1'b1;
      start      = 1'b0;
      n_features = '0;
      n_samples  = '0;
      in_valid   = 1'b0;
      in_data    = '0;
      out_ready  = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;

      run(32, 2, 100, 100, 0, 1, cyc);
      run(6, 1, 100, 100, 0, 1, cyc);
      run(8, 3, 100, 100, 1, 0, cyc);

      foreach (nf_bad[k]) begin
         @(negedge clk);
         start      = 1'b1;
         n_features = 6'(nf_bad[k]);
         n_samples  = 32'd3;
         @(negedge clk);
         start = 1'b0;
         check("bad_cfg_err", cfg_err, 1);
         check("bad_busy", busy, 0);
         check("bad_in_ready", in_ready, 0);
         check("bad_done", done, 0);
         @(negedge clk);
         check("bad_done_late", done, 0);
         check("bad_busy_late", busy, 0);
      end
      run(4, 2, 80, 80, 0, 0, cyc);

      run(10, 0, 100, 100, 0, 0, cyc);

      @(negedge clk);
      start      = 1'b1;
      n_features = 6'd32;
      n_samples  = 32'd1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_data  = {$urandom, $urandom};
         @(negedge clk);
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      check_idle_outputs("mid_reset");
      rst = 1'b0;
      @(negedge clk);
      check("mid_reset_no_done", done, 0);
      run(32, 2, 70, 70, 0, 0, cyc);

      for (int r = 0; r < 8; r++)
         run(2 * $urandom_range(1, 16), $urandom_range(1, 5),
             $urandom_range(30, 100), $urandom_range(30, 100), 0, 0, cyc);

`ifdef FEATURE_ASM_PINGPONG_EN
      run(32, 100, 100, 100, 0, 0, cyc);
      check("pingpong_throughput", (cyc <= 1604), 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
